// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key-length encodings, Nk/Nr lookup,
// Rcon table, key-expansion state enum and word-store sizing.
package aes_pkg;

    localparam logic [1:0] KEY_LEN_128  = 2'd0;
    localparam logic [1:0] KEY_LEN_192  = 2'd1;
    localparam logic [1:0] KEY_LEN_256  = 2'd2;
    localparam logic [1:0] KEY_LEN_RSVD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_EXPAND = 2'd2,
        ST_DONE   = 2'd3
    } ks_state_e;

    // Key length in 32-bit words; the reserved encoding maps to 0.
    function automatic logic [3:0] nk_of(input logic [1:0] key_len);
        logic [3:0] nk;
        case (key_len)
            KEY_LEN_128: nk = 4'd4;
            KEY_LEN_192: nk = 4'd6;
            KEY_LEN_256: nk = 4'd8;
            default:     nk = 4'd0;
        endcase
        return nk;
    endfunction

    // Round count; the reserved encoding maps to 0.
    function automatic logic [3:0] nr_of(input logic [1:0] key_len);
        logic [3:0] nr;
        case (key_len)
            KEY_LEN_128: nr = 4'd10;
            KEY_LEN_192: nr = 4'd12;
            KEY_LEN_256: nr = 4'd14;
            default:     nr = 4'd0;
        endcase
        return nr;
    endfunction

    // Round constant for i/Nk = 1..10; other indices never occur.
    function automatic logic [7:0] rcon_of(input logic [3:0] idx);
        logic [7:0] rc;
        case (idx)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // Enough words for the longest schedule the build supports.
    function automatic int word_store_depth(input int max_nk);
        return 4 * (max_nk + 7);
    endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: four byte-wide S-boxes applied across a 32-bit word.
module aes_subword (
    input  logic [31:0] word_val,
    output logic [31:0] sub_val
);

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        sbox_element u_sbox (
            .byte_val (word_val[8*b +: 8]),
            .sub_val  (sub_val[8*b +: 8])
        );
    end

endmodule

// File: rtl/sbox_element.sv
// AES forward S-box for one byte: multiplicative inverse in GF(2^8)
// (computed as a^254) followed by the standard affine transform.
module sbox_element (
    input  logic [7:0] byte_val,
    output logic [7:0] sub_val
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) begin
                p = p ^ aa;
            end else begin
                p = p;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 = product of a^2, a^4, ..., a^128; zero maps to zero.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] x);
        return x
             ^ {x[6:0], x[7]}
             ^ {x[5:0], x[7:6]}
             ^ {x[4:0], x[7:5]}
             ^ {x[3:0], x[7:4]}
             ^ 8'h63;
    endfunction

    // Pure combinational substitution.
    always_comb begin
        sub_val = affine(gf_inv(byte_val));
    end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128/192/256 key expansion: one schedule word per cycle into
// a register-array word store, then 128-bit round keys served by index.
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int MAX_NK  = 8,
    parameter bit REG_OUT = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] key,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [3:0]   nr,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_out
);

    localparam int DEPTH = word_store_depth(MAX_NK);
    localparam int IDX_W = $clog2(DEPTH);

    ks_state_e          state_r;
    ks_state_e          next_state_s;
    logic               accept_s;
    logic               reject_s;
    logic               legal_s;
    logic               last_word_s;

    logic [255:0]       key_r;
    logic [3:0]         nk_r;
    logic [3:0]         nr_tgt_r;
    logic [3:0]         nr_r;
    logic [3:0]         pos_r;       // i mod Nk
    logic [3:0]         rcon_idx_r;  // i / Nk for the next rotate step
    logic [IDX_W-1:0]   i_r;
    logic [IDX_W-1:0]   nw_last_s;
    logic               busy_r;
    logic               done_r;
    logic               err_r;

    logic [31:0]        w_r [DEPTH];
    logic [31:0]        prev_word_s;
    logic [31:0]        back_word_s;
    logic [31:0]        sub_in_s;
    logic [31:0]        sub_out_s;
    logic [31:0]        temp_s;
    logic [31:0]        new_word_s;

    logic               rd_valid_s;
    logic [3:0]         rd_idx_s;
    logic [IDX_W-1:0]   rd_base_s;
    logic [127:0]       rk_comb_s;

    assign legal_s     = (key_len != KEY_LEN_RSVD) && (nk_of(key_len) <= 4'(MAX_NK));
    assign nw_last_s   = IDX_W'({nr_tgt_r, 2'b11});
    assign last_word_s = (i_r == nw_last_s);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic and start accept/reject decode.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        reject_s     = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start && legal_s) begin
                    accept_s     = 1'b1;
                    next_state_s = ST_LOAD;
                end else if (start) begin
                    reject_s     = 1'b1;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_LOAD: begin
                next_state_s = ST_EXPAND;
            end
            ST_EXPAND: begin
                if (last_word_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_EXPAND;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Control registers: latched key, word counters and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_r      <= 256'd0;
            nk_r       <= 4'd0;
            nr_tgt_r   <= 4'd0;
            nr_r       <= 4'd0;
            pos_r      <= 4'd0;
            rcon_idx_r <= 4'd0;
            i_r        <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            err_r  <= reject_s;
            busy_r <= (next_state_s == ST_LOAD) || (next_state_s == ST_EXPAND);
            done_r <= (next_state_s == ST_DONE);
            if (accept_s) begin
                key_r    <= key;
                nk_r     <= nk_of(key_len);
                nr_tgt_r <= nr_of(key_len);
                nr_r     <= 4'd0;
            end
            if (state_r == ST_LOAD) begin
                i_r        <= IDX_W'(nk_r);
                pos_r      <= 4'd0;
                rcon_idx_r <= 4'd1;
            end else if (state_r == ST_EXPAND) begin
                i_r <= i_r + IDX_W'(1'b1);
                if (pos_r == nk_r - 4'd1) begin
                    pos_r <= 4'd0;
                end else begin
                    pos_r <= pos_r + 4'd1;
                end
                if (pos_r == 4'd0) begin
                    rcon_idx_r <= rcon_idx_r + 4'd1;
                end
                if (last_word_s) begin
                    nr_r <= nr_tgt_r;
                end
            end
        end
    end

    assign prev_word_s = w_r[i_r - IDX_W'(1'b1)];
    assign back_word_s = w_r[i_r - IDX_W'(nk_r)];

    // SubWord input: rotated on round boundaries, plain at the AES-256 midpoint.
    always_comb begin
        sub_in_s = prev_word_s;
        if (pos_r == 4'd0) begin
            sub_in_s = {prev_word_s[23:0], prev_word_s[31:24]};
        end else begin
            sub_in_s = prev_word_s;
        end
    end

    aes_subword u_subword (
        .word_val (sub_in_s),
        .sub_val  (sub_out_s)
    );

    // Select the temp term for the current word position.
    always_comb begin
        temp_s = prev_word_s;
        if (pos_r == 4'd0) begin
            temp_s = sub_out_s ^ {rcon_of(rcon_idx_r), 24'h000000};
        end else if ((nk_r == 4'd8) && (pos_r == 4'd4)) begin
            temp_s = sub_out_s;
        end else begin
            temp_s = prev_word_s;
        end
    end

    assign new_word_s = back_word_s ^ temp_s;

    // Word store: key words during LOAD, one expanded word per EXPAND cycle.
    // LOAD writes all MAX_NK slots; slots past Nk are rewritten by EXPAND
    // before anything reads them.
    always_ff @(posedge clk) begin
        if (state_r == ST_LOAD) begin
            for (int k = 0; k < MAX_NK; k++) begin
                w_r[IDX_W'(k)] <= key_r[255 - 32*k -: 32];
            end
        end else if (state_r == ST_EXPAND) begin
            w_r[i_r] <= new_word_s;
        end
    end

    // Round-key read: four parallel word reads, zero when not servable.
    always_comb begin
        rd_valid_s = done_r && (rk_idx <= nr_r);
        rd_idx_s   = 4'd0;
        if (rd_valid_s) begin
            rd_idx_s = rk_idx;
        end else begin
            rd_idx_s = 4'd0;
        end
        rd_base_s = IDX_W'({rd_idx_s, 2'b00});
        if (rd_valid_s) begin
            rk_comb_s = {w_r[rd_base_s],
                         w_r[rd_base_s + IDX_W'(2'd1)],
                         w_r[rd_base_s + IDX_W'(2'd2)],
                         w_r[rd_base_s + IDX_W'(2'd3)]};
        end else begin
            rk_comb_s = 128'd0;
        end
    end

    if (REG_OUT) begin : g_reg_out
        logic [127:0] rk_out_r;
        // Registered round key; cleared on an accepted start so a restart
        // hides the old schedule immediately.
        always_ff @(posedge clk) begin
            if (reset) begin
                rk_out_r <= 128'd0;
            end else if (accept_s) begin
                rk_out_r <= 128'd0;
            end else begin
                rk_out_r <= rk_comb_s;
            end
        end
        assign rk_out = rk_out_r;
    end else begin : g_comb_out
        assign rk_out = rk_comb_s;
    end

    assign busy = busy_r;
    assign done = done_r;
    assign err  = err_r;
    assign nr   = nr_r;

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: FIPS-197 vectors, random keys
// against a behavioural key-schedule model, illegal starts, reset and restart.
module tb_aes_key_expand;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, start, busy, done, err;
    logic [1:0]   key_len;
    logic [255:0] key;
    logic [3:0]   nr, rk_idx;
    logic [127:0] rk_out;

    logic         reset4, start4, busy4, done4, err4;
    logic [1:0]   key_len4;
    logic [255:0] key4;
    logic [3:0]   nr4, rk_idx4;
    logic [127:0] rk_out4;

    aes_key_expand #(.MAX_NK(8), .REG_OUT(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .key_len(key_len), .key(key),
        .busy(busy), .done(done), .err(err), .nr(nr), .rk_idx(rk_idx), .rk_out(rk_out)
    );

    aes_key_expand #(.MAX_NK(4), .REG_OUT(1'b0)) dut4 (
        .clk(clk), .reset(reset4), .start(start4), .key_len(key_len4), .key(key4),
        .busy(busy4), .done(done4), .err(err4), .nr(nr4), .rk_idx(rk_idx4), .rk_out(rk_out4)
    );

    int checks = 0;
    int errors = 0;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    // ---------------- reference model ----------------
    logic [7:0]  sbox_t [256];
    logic [31:0] model_w [60];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box by brute-force inverse search and bitwise affine matrix.
    task automatic build_sbox();
        logic [7:0] inv, s, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            for (int b = 0; b < 8; b++) begin
                s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
            end
            sbox_t[x] = s;
        end
    endtask

    function automatic logic [31:0] sub_w(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    task automatic build_model(input logic [255:0] k, input int nk);
        int nw;
        logic [31:0] t;
        logic [7:0] rc;
        nw = 4 * (nk + 7);
        for (int i = 0; i < nk; i++) model_w[i] = k[255 - 32*i -: 32];
        rc = 8'h01;
        for (int i = nk; i < nw; i++) begin
            t = model_w[i-1];
            if (i % nk == 0) begin
                t = sub_w({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_w(t);
            end
            model_w[i] = model_w[i-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] model_rk(input int r);
        return {model_w[4*r], model_w[4*r+1], model_w[4*r+2], model_w[4*r+3]};
    endfunction

    // ---------------- drivers (no checking) ----------------
    task automatic do_start(input logic [1:0] kl, input logic [255:0] k);
        key_len = kl; key = k; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic read_rk(input logic [3:0] idx, output logic [127:0] v);
        rk_idx = idx;
        @(posedge clk); #1;
        v = rk_out;
    endtask

    task automatic do_start4(input logic [1:0] kl, input logic [255:0] k);
        key_len4 = kl; key4 = k; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; reset4 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {busy, done, err}); end
        checks++; if (nr !== 4'd0) begin errors++; $display("FAIL reset_nr: got %0d want 0", nr); end
        checks++; if (rk_out !== 128'd0) begin errors++; $display("FAIL reset_rk: got %h want 0", rk_out); end
        checks++; if ({busy4, done4, err4, nr4} !== 7'd0) begin errors++; $display("FAIL reset_dut4: got %b want 0", {busy4, done4, err4, nr4}); end
        reset = 1'b0; reset4 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_fips();
        logic [1:0]   kl [3]   = '{2'd0, 2'd1, 2'd2};
        logic [255:0] kv [3]   = '{K128, K192, K256};
        int           nkv [3]  = '{4, 6, 8};
        int           latv [3] = '{41, 47, 53};
        logic [127:0] lastv [3] = '{128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
                                    128'he98ba06f448c773c8ecc720401002202,
                                    128'hfe4890d1e6188d0b046df344706c631e};
        int lat, nrv;
        logic [127:0] v;
        for (int t = 0; t < 3; t++) begin
            nrv = nkv[t] + 6;
            do_start(kl[t], kv[t]);
            wait_done(lat);
            checks++; if (lat != latv[t]) begin errors++; $display("FAIL fips%0d_latency: got %0d want %0d", t, lat, latv[t]); end
            checks++; if (nr !== 4'(nrv)) begin errors++; $display("FAIL fips%0d_nr: got %0d want %0d", t, nr, nrv); end
            read_rk(4'(nrv), v);
            checks++; if (v !== lastv[t]) begin errors++; $display("FAIL fips%0d_last_rk: got %h want %h", t, v, lastv[t]); end
            if (t == 0) begin
                read_rk(4'd1, v);
                checks++; if (v !== 128'ha0fafe1788542cb123a339392a6c7605) begin errors++; $display("FAIL fips0_rk1: got %h want a0fafe1788542cb123a339392a6c7605", v); end
            end
            build_model(kv[t], nkv[t]);
            for (int r = 0; r <= nrv; r++) begin
                read_rk(4'(r), v);
                checks++; if (v !== model_rk(r)) begin errors++; $display("FAIL fips%0d_rk%0d: got %h want %h", t, r, v, model_rk(r)); end
            end
        end
    endtask

    task automatic test_random();
        int lat, nk, nrv;
        logic [1:0] kl;
        logic [255:0] k;
        logic [127:0] v;
        for (int n = 0; n < 6; n++) begin
            kl = 2'(n % 3);
            nk = 4 + 2 * (n % 3);
            nrv = nk + 6;
            k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            do_start(kl, k);
            wait_done(lat);
            checks++; if (lat != 1 + 4*(nrv+1) - nk) begin errors++; $display("FAIL rand%0d_latency: got %0d want %0d", n, lat, 1 + 4*(nrv+1) - nk); end
            build_model(k, nk);
            for (int r = 0; r <= nrv; r++) begin
                read_rk(4'(r), v);
                checks++; if (v !== model_rk(r)) begin errors++; $display("FAIL rand%0d_rk%0d: got %h want %h", n, r, v, model_rk(r)); end
            end
        end
    endtask

    task automatic test_illegal();
        int lat;
        // From DONE: reserved key length is rejected and DONE is kept.
        do_start(2'd3, K128);
        checks++; if ({err, busy, done} !== 3'b101) begin errors++; $display("FAIL illegal_rsvd_pulse: got err,busy,done=%b want 101", {err, busy, done}); end
        @(posedge clk); #1;
        checks++; if ({err, busy} !== 2'b00) begin errors++; $display("FAIL illegal_rsvd_after: got err,busy=%b want 00", {err, busy}); end
        // MAX_NK=4 build refuses a 256-bit key.
        do_start4(2'd2, K256);
        checks++; if ({err4, busy4} !== 2'b10) begin errors++; $display("FAIL illegal_nk_pulse: got err,busy=%b want 10", {err4, busy4}); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({err4, busy4, done4} !== 3'b000) begin errors++; $display("FAIL illegal_nk_after: got err,busy,done=%b want 000", {err4, busy4, done4}); end
        // Same build still handles AES-128, read combinationally.
        do_start4(2'd0, K128);
        lat = 0;
        while (done4 !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
        checks++; if (lat != 41) begin errors++; $display("FAIL dut4_latency: got %0d want 41", lat); end
        rk_idx4 = 4'd10; #1;
        checks++; if (rk_out4 !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin errors++; $display("FAIL dut4_rk10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", rk_out4); end
        rk_idx4 = 4'd11; #1;
        checks++; if (rk_out4 !== 128'd0) begin errors++; $display("FAIL dut4_rk11: got %h want 0", rk_out4); end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [127:0] v;
        do_start(2'd2, K256);
        repeat (19) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL midreset_flags: got %b want 000", {busy, done, err}); end
        checks++; if (rk_out !== 128'd0 || nr !== 4'd0) begin errors++; $display("FAIL midreset_out: got rk=%h nr=%0d want 0", rk_out, nr); end
        do_start(2'd0, K128);
        wait_done(lat);
        checks++; if (lat != 41) begin errors++; $display("FAIL midreset_latency: got %0d want 41", lat); end
        read_rk(4'd10, v);
        checks++; if (v !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin errors++; $display("FAIL midreset_rk10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", v); end
    endtask

    task automatic test_back_to_back();
        int lat, err_seen;
        logic [255:0] ka;
        logic [127:0] v;
        ka = {$urandom, $urandom, $urandom, $urandom, 128'h0};
        do_start(2'd0, ka);
        lat = 0; err_seen = 0;
        while (done !== 1'b1 && lat < 200) begin
            start   = (lat % 7 == 3);
            key_len = 2'd2;
            key     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            lat++;
            if (err === 1'b1) err_seen++;
        end
        start = 1'b0;
        checks++; if (lat != 41) begin errors++; $display("FAIL busy_start_latency: got %0d want 41", lat); end
        checks++; if (err_seen != 0) begin errors++; $display("FAIL busy_start_err: got %0d pulses want 0", err_seen); end
        build_model(ka, 4);
        for (int r = 0; r <= 10; r++) begin
            read_rk(4'(r), v);
            checks++; if (v !== model_rk(r)) begin errors++; $display("FAIL busy_start_rk%0d: got %h want %h", r, v, model_rk(r)); end
        end
        read_rk(4'd11, v);
        checks++; if (v !== 128'd0) begin errors++; $display("FAIL bound_rk11: got %h want 0", v); end
        read_rk(4'd15, v);
        checks++; if (v !== 128'd0) begin errors++; $display("FAIL bound_rk15: got %h want 0", v); end
        // Restart from DONE.
        read_rk(4'd3, v);
        do_start(2'd1, K192);
        checks++; if ({done, busy} !== 2'b01) begin errors++; $display("FAIL restart_flags: got done,busy=%b want 01", {done, busy}); end
        checks++; if (rk_out !== 128'd0) begin errors++; $display("FAIL restart_rk_cleared: got %h want 0", rk_out); end
        @(posedge clk); #1;
        checks++; if (rk_out !== 128'd0) begin errors++; $display("FAIL restart_rk_hidden: got %h want 0", rk_out); end
        wait_done(lat);
        checks++; if (lat != 46) begin errors++; $display("FAIL restart_latency: got %0d more cycles want 46", lat); end
        build_model(K192, 6);
        read_rk(4'd12, v);
        checks++; if (v !== model_rk(12)) begin errors++; $display("FAIL restart_rk12: got %h want %h", v, model_rk(12)); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; key_len = 2'd0; key = 256'd0; rk_idx = 4'd0;
        reset4 = 1'b1; start4 = 1'b0; key_len4 = 2'd0; key4 = 256'd0; rk_idx4 = 4'd0;
        build_sbox();
        @(posedge clk); #1;
        test_reset();
        test_fips();
        test_random();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
